// File: rtl/ctrl_pkg.sv
// Shared constants and FSM state encoding for the weight-fetch path.
package ctrl_pkg;

    localparam int unsigned LAT_CNT_W                 = 3;
    localparam int unsigned DEFAULT_BRAM_READ_LATENCY = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_VALID = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/bram_addr_wrap.sv
// Combinational pointer advance inside [base_addr, end_addr], folding any
// overshoot past end back to the start of the range.
module bram_addr_wrap #(
    parameter int unsigned AW = 12
) (
    input  logic [AW-1:0] ptr,
    input  logic [1:0]    inc,
    input  logic [AW-1:0] base_addr,
    input  logic [AW-1:0] end_addr,
    output logic [AW-1:0] next_ptr_c,
    output logic          wrap_c
);

    localparam int unsigned XW = AW + 2;

    logic [XW-1:0] sum;
    logic [XW-1:0] span;
    logic [XW-1:0] off;

    // Overshoot is at most 2, so two conditional subtractions cover a span of 1.
    always_comb begin
        sum    = XW'(ptr) + XW'(inc);
        span   = XW'(end_addr) - XW'(base_addr) + XW'(1);
        wrap_c = (sum > XW'(end_addr));
        off    = sum - XW'(end_addr) - XW'(1);
        if (off >= span) off = off - span;
        if (off >= span) off = off - span;
        next_ptr_c = wrap_c ? AW'(XW'(base_addr) + off) : AW'(sum);
    end

endmodule

// File: rtl/weight_bram_addr_gen.sv
// Weight BRAM read sequencer: pointer/wrap management, dual-port issue,
// read-latency wait and hold of the fetched word pair.
module weight_bram_addr_gen
    import ctrl_pkg::*;
#(
    parameter int unsigned BRAM_ADDRESS_WIDTH = 12,
    parameter int unsigned WEIGHT_DATA_WIDTH  = 32,
    parameter int unsigned BRAM_READ_LATENCY  = DEFAULT_BRAM_READ_LATENCY
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          address_reset,
    input  logic                          bram_control_add1,
    input  logic                          bram_control_add2,
    input  logic                          bram_port_sel,
    input  logic [BRAM_ADDRESS_WIDTH-1:0] weight_base_addr,
    input  logic [BRAM_ADDRESS_WIDTH-1:0] weight_end_addr,
    output logic                          bram_a_en,
    output logic [BRAM_ADDRESS_WIDTH-1:0] bram_a_addr,
    input  logic [WEIGHT_DATA_WIDTH-1:0]  bram_a_dout,
    output logic                          bram_b_en,
    output logic [BRAM_ADDRESS_WIDTH-1:0] bram_b_addr,
    input  logic [WEIGHT_DATA_WIDTH-1:0]  bram_b_dout,
    output logic [WEIGHT_DATA_WIDTH-1:0]  weight_data,
    output logic                          weight_from_bram_valid,
    output logic                          addr_wrap
);

    localparam int unsigned AW = BRAM_ADDRESS_WIDTH;
    localparam int unsigned DW = WEIGHT_DATA_WIDTH;

    fetch_state_e         state_q, state_d;
    logic [AW-1:0]        ptr_q, ptr_d;
    logic [AW-1:0]        base_q, base_d;
    logic [AW-1:0]        end_q, end_d;
    logic [AW-1:0]        b_addr_q, b_addr_d;
    logic [LAT_CNT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [DW-1:0]        hold_a_q, hold_a_d;
    logic [DW-1:0]        hold_b_q, hold_b_d;
    logic                 en_q, en_d;
    logic                 valid_q, valid_d;
    logic                 wrap_q, wrap_d;

    logic                 advance;
    logic [1:0]           inc;
    logic [AW-1:0]        adv_ptr;
    logic                 adv_wrap;
    logic                 b_wrap_unused;

    assign advance = bram_control_add1 | bram_control_add2;
    assign inc     = {bram_control_add2, bram_control_add1};

    bram_addr_wrap #(.AW(AW)) u_ptr_wrap (
        .ptr        (ptr_q),
        .inc        (inc),
        .base_addr  (base_q),
        .end_addr   (end_q),
        .next_ptr_c (adv_ptr),
        .wrap_c     (adv_wrap)
    );

    // Port B reads the word after the pointer, using the bounds in force next cycle.
    bram_addr_wrap #(.AW(AW)) u_port_b_wrap (
        .ptr        (ptr_d),
        .inc        (2'd1),
        .base_addr  (base_d),
        .end_addr   (end_d),
        .next_ptr_c (b_addr_d),
        .wrap_c     (b_wrap_unused)
    );

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        base_d    = base_q;
        end_d     = end_q;
        lat_cnt_d = lat_cnt_q;
        hold_a_d  = hold_a_q;
        hold_b_d  = hold_b_q;
        wrap_d    = 1'b0;

        if (address_reset) begin
            state_d = ST_ISSUE;
            ptr_d   = weight_base_addr;
            base_d  = weight_base_addr;
            end_d   = weight_end_addr;
        end else if (advance && (state_q != ST_IDLE)) begin
            // Any advance aborts an in-flight fetch and reissues.
            state_d = ST_ISSUE;
            ptr_d   = adv_ptr;
            wrap_d  = adv_wrap;
            if (adv_wrap) begin
                base_d = weight_base_addr;
                end_d  = weight_end_addr;
            end
        end else begin
            case (state_q)
                ST_ISSUE: begin
                    state_d   = ST_WAIT;
                    lat_cnt_d = LAT_CNT_W'(BRAM_READ_LATENCY);
                end
                ST_WAIT: begin
                    lat_cnt_d = lat_cnt_q - LAT_CNT_W'(1);
                    if (lat_cnt_q <= LAT_CNT_W'(1)) begin
                        hold_a_d = bram_a_dout;
                        hold_b_d = bram_b_dout;
                        state_d  = ST_VALID;
                    end
                end
                default: state_d = state_q;
            endcase
        end

        en_d    = (state_d == ST_ISSUE);
        valid_d = (state_d == ST_VALID);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            base_q    <= '0;
            end_q     <= '0;
            b_addr_q  <= '0;
            lat_cnt_q <= '0;
            hold_a_q  <= '0;
            hold_b_q  <= '0;
            en_q      <= 1'b0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            base_q    <= base_d;
            end_q     <= end_d;
            b_addr_q  <= b_addr_d;
            lat_cnt_q <= lat_cnt_d;
            hold_a_q  <= hold_a_d;
            hold_b_q  <= hold_b_d;
            en_q      <= en_d;
            valid_q   <= valid_d;
            wrap_q    <= wrap_d;
        end
    end

    assign bram_a_en              = en_q;
    assign bram_b_en              = en_q;
    assign bram_a_addr            = ptr_q;
    assign bram_b_addr            = b_addr_q;
    assign weight_from_bram_valid = valid_q;
    assign addr_wrap              = wrap_q;
    assign weight_data            = bram_port_sel ? hold_b_q : hold_a_q;

endmodule
